display_reader: RTL and testbench
=================================

# display_reader

Seven-segment pattern reader: the receive-side counterpart of the team's hex-to-segment display decoder. It samples a 7-bit active-high segment bus, waits until the pattern has been stable for a programmable number of cycles, then converts it back to a 4-bit hex digit. It reports each settled pattern exactly once, as a valid, error or blank event. It is used to read back or monitor digit drivers in self-checking designs and front-panel capture logic.

## Interface
- STABLE_CYCLES, 4, number of consecutive matching samples required before a pattern is reported; legal range 1..255.
- Clock  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- Segments  input  7  segment bus; bit 6 = a, 5 = b, 4 = c, 3 = d, 2 = e, 1 = f, 0 = g; 1 = segment lit.
- Value  output  4  last successfully decoded hex digit; registered.
- Valid  output  1  one-cycle pulse: Value was just updated from a legal digit pattern.
- Error  output  1  one-cycle pulse: a settled pattern is neither a digit nor blank.
- Blank  output  1  level: the last reported pattern was 0x00, i.e. all segments off.

## Operation
- Legal patterns, Segments in hex, mapped to a digit:
  - 0:7E, 1:30, 2:6D, 3:79, 4:33, 5:5B, 6:5F, 7:70
  - 8:7F, 9:7B, A:77, b:1F, C:4E, d:3D, E:4F, F:47
- 0x00 is blank. Every other code is illegal.
- Internal state:
  - Sample register S (7 bits).
  - Counter Cnt (8 bits).
  - FSM with two states: TRACK (counting toward report) and HELD (current pattern already reported).
- Every rising edge, not in reset:
  - Segments != S: S <= Segments, Cnt <= 0, state <= TRACK. This applies in either state.
  - Segments == S, state TRACK, Cnt < STABLE_CYCLES-1: Cnt <= Cnt+1.
  - Segments == S, state TRACK, Cnt == STABLE_CYCLES-1: report, then state <= HELD.
  - Segments == S, state HELD: no change; Cnt is frozen.
- Report action depends on the decoded pattern:
  - Legal digit: Value <= digit, Valid <= 1, Blank <= 0.
  - Blank: Blank <= 1, Value unchanged, no pulse.
  - Illegal: Error <= 1, Value and Blank unchanged.
- Valid and Error are cleared on every edge on which no report occurs, so they are single-cycle pulses. They are mutually exclusive.
- A glitch shorter than the stability window discards the pending count. Returning to a previously reported pattern after any change is reported again as a new event.

## Timing
- Reset values, applied on the first edge with Reset=1:
  - S = 0x00, Cnt = 0, state = TRACK.
  - Value = 0, Valid = 0, Error = 0, Blank = 0.
- Reset overrides all activity, including a report due on the same edge; that report is lost.
- Latency: pattern P (≠ S) is present at edge 0 and held.
  - Report outputs are visible after edge STABLE_CYCLES.
  - Valid/Error stay high for the cycle between edges STABLE_CYCLES and STABLE_CYCLES+1.
- Reset releases with Segments = 0x00: Blank rises after edge STABLE_CYCLES-1, counted from the first non-reset edge. S already equals 0x00, so edge 0 counts as a match.
- STABLE_CYCLES = 1: report occurs after edge 1.
- Segments changing on exactly the report edge: no report; the new pattern restarts at Cnt = 0.
- Segments is sampled directly, with no synchronizer; the source must be synchronous to Clock.
- No back-pressure. A consumer must capture Valid/Error in the pulse cycle.

## Test plan
- Reset, then Segments = 0x6D held, STABLE_CYCLES = 4 -> Value = 2 and Valid high for exactly one cycle, after edge 4 counted from the first edge seeing 0x6D. No further pulses while the pattern is held.
- Sweep all 16 legal codes, 0x7E..0x47, each held 10 cycles -> Value follows 0..F with one Valid per digit. Error and Blank stay 0 throughout.
- 0x79 held 2 cycles, then 0x33 held 10 cycles -> no report for 0x79. Value = 4 with Valid, latency measured from the 0x33 change.
- 0x7F stable and reported, then 0x00 held 10 cycles -> Blank = 1 with no Valid and Value still 8. Then 0x30 held -> Blank = 0, Value = 1, Valid pulse.
- Segments = 0x01 held -> single Error pulse, Value unchanged. Then 0x7F → 0x7E for 1 cycle → 0x7F -> 8 is reported a second time after stabilising.
- Reset asserted on the edge where the 0x5B report is due -> all outputs 0 and no Valid. After release with 0x5B still held, Value = 5 after edge STABLE_CYCLES.

Source files
------------

// File: rtl/display_reader.sv
// display_reader: seven-segment pattern reader.
// Waits for a stable segment pattern, then reports its hex digit once.
module display_reader #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] segments_i,
    output logic [3:0] value_o,
    output logic       valid_o,
    output logic       error_o,
    output logic       blank_o
);

    typedef enum logic {
        TRACK,
        HELD
    } state_e;

    localparam logic [7:0] LAST = 8'(STABLE_CYCLES - 1);

    state_e     state_q, state_d;
    logic [6:0] samp_q, samp_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] value_q, value_d;
    logic       valid_q, valid_d;
    logic       error_q, error_d;
    logic       blank_q, blank_d;

    logic [3:0] dig;
    logic       legal;

    // Map the sampled pattern back to a hex digit.
    always_comb begin
        dig   = 4'h0;
        legal = 1'b1;
        unique case (samp_q)
            7'h7E: dig = 4'h0;
            7'h30: dig = 4'h1;
            7'h6D: dig = 4'h2;
            7'h79: dig = 4'h3;
            7'h33: dig = 4'h4;
            7'h5B: dig = 4'h5;
            7'h5F: dig = 4'h6;
            7'h70: dig = 4'h7;
            7'h7F: dig = 4'h8;
            7'h7B: dig = 4'h9;
            7'h77: dig = 4'hA;
            7'h1F: dig = 4'hB;
            7'h4E: dig = 4'hC;
            7'h3D: dig = 4'hD;
            7'h4F: dig = 4'hE;
            7'h47: dig = 4'hF;
            default: legal = 1'b0;
        endcase
    end

    // Stability tracking and report generation.
    always_comb begin
        state_d = state_q;
        samp_d  = samp_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        valid_d = 1'b0;
        error_d = 1'b0;
        blank_d = blank_q;
        if (segments_i != samp_q) begin
            samp_d  = segments_i;
            cnt_d   = 8'd0;
            state_d = TRACK;
        end else if (state_q == TRACK) begin
            if (cnt_q == LAST) begin
                state_d = HELD;
                if (legal) begin
                    value_d = dig;
                    valid_d = 1'b1;
                    blank_d = 1'b0;
                end else if (samp_q == 7'h00) begin
                    blank_d = 1'b1;
                end else begin
                    error_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // State and output registers; reset drops any pending report.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= TRACK;
            samp_q  <= 7'h00;
            cnt_q   <= 8'd0;
            value_q <= 4'h0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
            blank_q <= 1'b0;
        end else begin
            state_q <= state_d;
            samp_q  <= samp_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            valid_q <= valid_d;
            error_q <= error_d;
            blank_q <= blank_d;
        end
    end

    assign value_o = value_q;
    assign valid_o = valid_q;
    assign error_o = error_q;
    assign blank_o = blank_q;

endmodule

// File: tb/tb_display_reader.sv
// tb_display_reader: directed checks for display_reader.
// Second instance covers the single-cycle stability window.
module tb_display_reader;

    localparam int SC = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg = 7'h00;
    logic [3:0] value, value1;
    logic       valid, valid1;
    logic       error, error1;
    logic       blank, blank1;

    int total = 0;
    int bad   = 0;

    int nv, ne, nb, fv, fb, fv1;
    int acc_e, acc_b;

    logic [6:0] codes [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    always #5 clk = ~clk;

    display_reader #(.STABLE_CYCLES(SC)) dut (
        .clk_i(clk), .rst_i(rst), .segments_i(seg),
        .value_o(value), .valid_o(valid),
        .error_o(error), .blank_o(blank)
    );

    display_reader #(.STABLE_CYCLES(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .segments_i(seg),
        .value_o(value1), .valid_o(valid1),
        .error_o(error1), .blank_o(blank1)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold a pattern for n edges; edge index 0 is the first edge seeing it.
    task automatic run(input logic [6:0] s, input int n);
        seg = s;
        nv = 0; ne = 0; nb = 0;
        fv = -1; fb = -1; fv1 = -1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (valid) begin
                nv++;
                if (fv < 0) fv = i;
            end
            if (error) ne++;
            if (blank) begin
                nb++;
                if (fb < 0) fb = i;
            end
            if (valid1 && fv1 < 0) fv1 = i;
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_value"}, value, 0);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_blank"}, blank, 0);
    endtask

    initial begin
        rst = 1'b1;
        seg = 7'h00;
        tick();
        tick();
        chk_idle("reset");

        rst = 1'b0;
        run(7'h6D, 12);
        chk("d2_npulse", nv, 1);
        chk("d2_latency", fv, SC);
        chk("d2_value", value, 2);
        chk("d2_err", ne, 0);
        chk("sc1_latency", fv1, 1);
        chk("sc1_value", value1, 2);

        acc_e = 0;
        acc_b = 0;
        for (int d = 0; d < 16; d++) begin
            run(codes[d], 10);
            chk($sformatf("sweep%0d_npulse", d), nv, 1);
            chk($sformatf("sweep%0d_lat", d), fv, SC);
            chk($sformatf("sweep%0d_value", d), value, d);
            chk($sformatf("sweep%0d_sc1", d), fv1, 1);
            acc_e += ne;
            acc_b += nb;
        end
        chk("sweep_errors", acc_e, 0);
        chk("sweep_blank", acc_b, 0);

        run(7'h79, 2);
        chk("glitch_npulse", nv, 0);
        run(7'h33, 10);
        chk("d4_npulse", nv, 1);
        chk("d4_latency", fv, SC);
        chk("d4_value", value, 4);

        run(7'h79, SC);
        chk("edgechg_npulse", nv, 0);
        run(7'h33, 10);
        chk("edgechg_next", nv, 1);
        chk("edgechg_lat", fv, SC);

        run(7'h7F, 10);
        chk("d8_value", value, 8);
        run(7'h00, 10);
        chk("blank_npulse", nv, 0);
        chk("blank_level", blank, 1);
        chk("blank_rise", fb, SC);
        chk("blank_value", value, 8);
        run(7'h30, 10);
        chk("unblank_level", blank, 0);
        chk("unblank_value", value, 1);
        chk("unblank_npulse", nv, 1);

        run(7'h01, 10);
        chk("illegal_nerr", ne, 1);
        chk("illegal_nvalid", nv, 0);
        chk("illegal_value", value, 1);
        chk("illegal_blank", blank, 0);
        run(7'h7F, 10);
        chk("rep1_npulse", nv, 1);
        run(7'h7E, 1);
        chk("blip_npulse", nv, 0);
        run(7'h7F, 10);
        chk("rep2_npulse", nv, 1);
        chk("rep2_latency", fv, SC);
        chk("rep2_value", value, 8);

        run(7'h5B, SC);
        chk("prerst_npulse", nv, 0);
        rst = 1'b1;
        tick();
        chk_idle("rst_on_report");
        rst = 1'b0;
        run(7'h5B, 10);
        chk("d5_npulse", nv, 1);
        chk("d5_latency", fv, SC);
        chk("d5_value", value, 5);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        run(7'h00, 8);
        chk("rstblank_rise", fb, SC - 1);
        chk("rstblank_npulse", nv, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
